// File: rtl/sln_pkg.sv
// sln_pkg: shared state type, default fixed-point format and saturating fixed-point helpers
package sln_pkg;
   typedef enum logic [2:0] {S_IDLE, S_FWD, S_ACT, S_WAIT, S_BWD} state_t;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_FRAC_W = 8;
   localparam int ONE = 1 << DEF_FRAC_W;
   localparam int MAX_VAL = (1 << (DEF_DATA_W - 1)) - 1;
   localparam int MIN_VAL = -(1 << (DEF_DATA_W - 1));
   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return v > hi ? hi : (v < lo ? lo : v);
   endfunction
   function automatic logic signed [63:0] mul_shift(input logic signed [63:0] a, input logic signed [63:0] b, input int f);
      return (a * b) >>> f;
   endfunction
endpackage

// File: rtl/sln_mac.sv
// sln_mac: signed multiply with saturated fixed-point product and a registered accumulator
module sln_mac import sln_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int ACC_W  = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [DATA_W-1:0] prod_q,
   output logic signed [DATA_W-1:0] pre
);
   logic signed [ACC_W-1:0] acc;
   logic signed [63:0] prod;
   assign prod = 64'(a) * 64'(b);
   assign prod_q = DATA_W'(sat(prod >>> FRAC_W, DATA_W));
   assign pre = DATA_W'(sat(64'(acc >>> FRAC_W), DATA_W));
   always_ff @(posedge clk or posedge rst)
      if (rst) acc <= '0;
      else if (clr) acc <= '0;
      else if (en) acc <= acc + ACC_W'(prod);
endmodule

// File: rtl/seq_learning_neuron.sv
// seq_learning_neuron: time-multiplexed fixed-point neuron with forward pass, activation and in-place backprop training
module seq_learning_neuron import sln_pkg::*; #(
   parameter int N_INPUTS = 32,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int FRAC_W   = DEF_FRAC_W,
   parameter int ACC_W    = 40,
   parameter int ACT_MODE = 0,
   parameter int IDX_W    = $clog2(N_INPUTS + 1)
) (
   input  logic                         sln_clock,
   input  logic                         sln_reset,
   input  logic                         sln_in_valid,
   output logic                         sln_in_ready,
   input  logic [N_INPUTS*DATA_W-1:0]   sln_dendrites,
   input  logic [N_INPUTS-1:0]          sln_enabled,
   output logic                         sln_axon_valid,
   output logic signed [DATA_W-1:0]    sln_axon,
   input  logic                         sln_bp_valid,
   output logic                         sln_bp_ready,
   input  logic signed [DATA_W-1:0]    sln_backprop,
   input  logic signed [DATA_W-1:0]    sln_train_rate,
   output logic                         sln_bpc_valid,
   output logic [IDX_W-1:0]             sln_bpc_index,
   output logic signed [DATA_W-1:0]    sln_bpc_data,
   output logic                         sln_bpc_last,
   input  logic                         sln_wr_en,
   input  logic [IDX_W-1:0]             sln_wr_addr,
   input  logic signed [DATA_W-1:0]    sln_wr_data
);
   localparam logic signed [DATA_W-1:0] ONE_Q = DATA_W'(1 << FRAC_W);
   localparam logic signed [DATA_W-1:0] NEG_ONE = -ONE_Q;
   localparam logic signed [DATA_W-1:0] ZERO = '0;
   state_t state, state_n;
   // Slot N_INPUTS of x/mask is a constant 1.0 input so the bias rides the same datapath
   logic signed [DATA_W-1:0] w [0:N_INPUTS];
   logic signed [DATA_W-1:0] x [0:N_INPUTS];
   logic [N_INPUTS:0] mask;
   logic [IDX_W-1:0] idx;
   logic signed [DATA_W-1:0] axon_r, delta, step, d_in, mac_a, mac_b, prod_q, pre, act_axon, w_upd;
   logic deriv, act_deriv, last_idx, accept;
   assign last_idx = idx == IDX_W'(N_INPUTS);
   assign accept = state == S_IDLE && sln_in_valid;
   assign d_in = deriv ? sln_backprop : ZERO;
   assign mac_a = state == S_WAIT ? sln_train_rate : state == S_BWD ? delta : (mask[idx] ? w[idx] : ZERO);
   assign mac_b = state == S_WAIT ? d_in : state == S_BWD ? w[idx] : x[idx];
   assign act_axon = ACT_MODE == 1 ? (pre > ZERO ? pre : ZERO) : (pre > ONE_Q ? ONE_Q : (pre < NEG_ONE ? NEG_ONE : pre));
   assign act_deriv = ACT_MODE == 1 ? pre > ZERO : (pre > NEG_ONE && pre < ONE_Q);
   assign w_upd = mask[idx] ? DATA_W'(sat(64'(w[idx]) + mul_shift(64'(step), 64'(x[idx]), FRAC_W), DATA_W)) : ZERO;
   sln_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
      .clk(sln_clock), .rst(sln_reset), .clr(accept), .en(state == S_FWD),
      .a(mac_a), .b(mac_b), .prod_q(prod_q), .pre(pre)
   );
   assign sln_in_ready = state == S_IDLE;
   assign sln_bp_ready = state == S_WAIT;
   assign sln_axon_valid = state == S_WAIT;
   assign sln_axon = axon_r;
   assign sln_bpc_valid = state == S_BWD && !last_idx;
   assign sln_bpc_index = sln_bpc_valid ? idx : '0;
   assign sln_bpc_data = sln_bpc_valid && mask[idx] ? prod_q : ZERO;
   assign sln_bpc_last = sln_bpc_valid && idx == IDX_W'(N_INPUTS - 1);
   always_ff @(posedge sln_clock or posedge sln_reset)
      if (sln_reset) state <= S_IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (sln_in_valid) state_n = S_FWD;
         S_FWD: if (last_idx) state_n = S_ACT;
         S_ACT: state_n = S_WAIT;
         S_WAIT: if (sln_bp_valid) state_n = S_BWD;
         S_BWD: if (last_idx) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge sln_clock or posedge sln_reset)
      if (sln_reset) begin
         for (int i = 0; i <= N_INPUTS; i++) begin
            w[i] <= '0;
            x[i] <= '0;
         end
         mask <= '0;
         idx <= '0;
         axon_r <= '0;
         deriv <= 1'b0;
         delta <= '0;
         step <= '0;
      end else begin
         idx <= (state == S_FWD || state == S_BWD) && !last_idx ? idx + IDX_W'(1) : '0;
         if (state == S_IDLE && sln_wr_en && sln_wr_addr <= IDX_W'(N_INPUTS)) w[sln_wr_addr] <= sln_wr_data;
         if (accept) begin
            for (int i = 0; i < N_INPUTS; i++) x[i] <= sln_dendrites[i*DATA_W +: DATA_W];
            x[N_INPUTS] <= ONE_Q;
            mask <= {1'b1, sln_enabled};
         end
         if (state == S_ACT) begin
            axon_r <= act_axon;
            deriv <= act_deriv;
         end
         if (state == S_WAIT && sln_bp_valid) begin
            delta <= d_in;
            step <= prod_q;
         end
         if (state == S_BWD) w[idx] <= w_upd;
      end
endmodule
